instr_encoder: RTL

- Inverse of the opcode decoder: packs a kind (opcode_t from package opcode_type) plus instruction fields into a 32-bit RV32I instruction word.
- Feeds the instruction-memory loader and self-checking benches: the bench generates words here and decodes them back.
- Structure: valid/ready input stage, one encode register, output FIFO, counters of encoded and flagged words.

---
 rtl/opcode_type.sv | 18 +
 rtl/instr_encoder_if.sv | 28 ++
 rtl/instr_encoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/opcode_type.sv
// Instruction kinds shared by the RV32I encoder and the benches that decode its words.
package opcode_type;

   typedef enum logic [3:0] {
      lui,
      auipc,
      jal,
      jalr,
      branch_type,
      load_type,
      store_type,
      imm_arith_type,
      reg_arith_type,
      fence_type,
      system_type
   } opcode_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of instr_encoder: valid/ready request in, FIFO head out.
interface instr_encoder_if;

   logic                      in_valid;
   logic                      in_ready;
   opcode_type::opcode_t      in_kind;
   logic [4:0]                in_rd;
   logic [4:0]                in_rs1;
   logic [4:0]                in_rs2;
   logic [2:0]                in_funct3;
   logic [6:0]                in_funct7;
   logic [31:0]               in_imm;
   logic                      out_valid;
   logic                      out_ready;
   logic [31:0]               out_instr;
   logic                      out_err;

   modport master (
      output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err
   );

   modport slave (
      input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_err
   );

endinterface

// File: rtl/instr_encoder.sv
// Packs an opcode kind plus fields into an RV32I word: input stage, encoder, output FIFO.
// Optional macro INSTR_ENC_RANGE_CHECK_EN flags words whose fields do not fit their format.
module instr_encoder
   import opcode_type::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   instr_encoder_if.slave    bus,
   output logic [CNT_W-1:0]  enc_count,
   output logic [CNT_W-1:0]  err_count
);

   localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FillW = $clog2(DEPTH + 1);

   logic             s1_valid_q, s1_valid_d;
   opcode_t          s1_kind_q, s1_kind_d;
   logic [4:0]       s1_rd_q, s1_rd_d, s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
   logic [2:0]       s1_funct3_q, s1_funct3_d;
   logic [6:0]       s1_funct7_q, s1_funct7_d;
   logic [31:0]      s1_imm_q, s1_imm_d;

   logic [32:0]      mem_q [DEPTH];
   logic [32:0]      mem_d [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FillW-1:0] fill_q, fill_d;
   logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;

   logic             accept, push, pop, is_shift;
   logic [31:0]      enc_instr;
   logic             enc_err;

`ifdef INSTR_ENC_RANGE_CHECK_EN
   logic signed [31:0] imm_s;
   assign imm_s = s1_imm_q;
`endif

   assign is_shift = (s1_funct3_q == 3'b001) || (s1_funct3_q == 3'b101);

   always_comb begin
      enc_instr = '0;
      enc_err   = 1'b0;
      case (s1_kind_q)
         lui:            enc_instr = {s1_imm_q[31:12], s1_rd_q, 7'b0110111};
         auipc:          enc_instr = {s1_imm_q[31:12], s1_rd_q, 7'b0010111};
         jal:            enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                                      s1_imm_q[19:12], s1_rd_q, 7'b1101111};
         jalr:           enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, 7'b1100111};
         branch_type:    enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q,
                                      s1_funct3_q, s1_imm_q[4:1], s1_imm_q[11], 7'b1100011};
         load_type:      enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, 7'b0000011};
         store_type:     enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                      s1_imm_q[4:0], 7'b0100011};
         imm_arith_type: begin
            if (is_shift) begin
               enc_instr = {s1_funct7_q, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                            7'b0010011};
            end else begin
               enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, 7'b0010011};
            end
         end
         reg_arith_type: enc_instr = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q,
                                      7'b0110011};
         fence_type:     enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, 7'b0001111};
         system_type:    enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, 7'b1110011};
         default:        enc_err   = 1'b1;
      endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
      // Flagged words are still emitted from the truncated fields built above.
      case (s1_kind_q)
         lui, auipc:  if (s1_imm_q[11:0] != 12'h000) enc_err = 1'b1;
         jal:         if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574 || s1_imm_q[0]) begin
                         enc_err = 1'b1;
                      end
         branch_type: if (imm_s < -32'sd4096 || imm_s > 32'sd4094 || s1_imm_q[0]) begin
                         enc_err = 1'b1;
                      end
         jalr, load_type, store_type, fence_type: begin
            if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_err = 1'b1;
         end
         system_type: if (imm_s < 32'sd0 || imm_s > 32'sd4095) enc_err = 1'b1;
         imm_arith_type: begin
            if (is_shift) begin
               if (imm_s < 32'sd0 || imm_s > 32'sd31) enc_err = 1'b1;
            end else if (imm_s < -32'sd2048 || imm_s > 32'sd2047) begin
               enc_err = 1'b1;
            end
         end
         default: ;
      endcase
`endif
   end

   assign bus.out_valid = (fill_q != '0);
   assign pop           = bus.out_valid && bus.out_ready;
   assign push          = s1_valid_q && ((fill_q < FillW'(DEPTH)) || pop);
   assign bus.in_ready  = !s1_valid_q || push;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
   assign bus.out_err   = bus.out_valid ? mem_q[rd_ptr_q][32] : 1'b0;
   assign enc_count     = enc_cnt_q;
   assign err_count     = err_cnt_q;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_kind_d   = s1_kind_q;
      s1_rd_d     = s1_rd_q;
      s1_rs1_d    = s1_rs1_q;
      s1_rs2_d    = s1_rs2_q;
      s1_funct3_d = s1_funct3_q;
      s1_funct7_d = s1_funct7_q;
      s1_imm_d    = s1_imm_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      enc_cnt_d   = enc_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (push) begin
         s1_valid_d      = 1'b0;
         mem_d[wr_ptr_q] = {enc_err, enc_instr};
         wr_ptr_d        = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
         enc_cnt_d       = enc_cnt_q + CNT_W'(1);
         if (enc_err) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      if (push && !pop) fill_d = fill_q + FillW'(1);
      if (pop && !push) fill_d = fill_q - FillW'(1);
      if (accept) begin
         s1_valid_d  = 1'b1;
         s1_kind_d   = bus.in_kind;
         s1_rd_d     = bus.in_rd;
         s1_rs1_d    = bus.in_rs1;
         s1_rs2_d    = bus.in_rs2;
         s1_funct3_d = bus.in_funct3;
         s1_funct7_d = bus.in_funct7;
         s1_imm_d    = bus.in_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         enc_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         enc_cnt_q  <= enc_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Payload storage is qualified by s1_valid_q / fill_q, so it carries no reset.
   always_ff @(posedge clk) begin
      s1_kind_q   <= s1_kind_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_funct3_q <= s1_funct3_d;
      s1_funct7_q <= s1_funct7_d;
      s1_imm_q    <= s1_imm_d;
      mem_q       <= mem_d;
   end

endmodule
